// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder state encoding, R/W bit position and the
// default device address also used by the on-chip I2C master.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      TX_BYTE,
      TX_ACK,
      RX_BYTE,
      RX_ACK,
      WAIT_STOP
   } i2cState_t;

   localparam int         RW_BIT               = 0;
   localparam logic [6:0] I2C_DEFAULT_DEV_ADDR = 7'h4B;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/i2c_temp_responder_if.sv
// Bus-side and register-side signals of the temperature-sensor responder,
// with the responder (slave) and bus-driver/test (master) views.
interface i2c_temp_responder_if;

   logic        scl_in;
   logic        sda_in;
   logic        sda_pull_low;
   logic [15:0] temp_data;
   logic [7:0]  ptr_reg;
   logic        busy;
   logic        rd_done;
   logic        wr_done;

   modport slave (
      input  scl_in, sda_in, temp_data,
      output sda_pull_low, ptr_reg, busy, rd_done, wr_done
   );

   modport master (
      output scl_in, sda_in, temp_data,
      input  sda_pull_low, ptr_reg, busy, rd_done, wr_done
   );

endinterface

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: synchroniser, optional 3-sample majority filter
// (I2C_GLITCH_FILTER_EN), edge detection and START/STOP decode.
module i2c_line_cond import i2c_pkg::*; #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_200K,
   input  logic reset,
   input  logic scl_i,
   input  logic sda_i,
   output logic sdaLevel_o,
   output logic sclRise_o,
   output logic sclFall_o,
   output logic start_o,
   output logic stop_o
);

   logic [SYNC_STAGES-1:0] sclSync_q;
   logic [SYNC_STAGES-1:0] sdaSync_q;
   logic sclSynced, sdaSynced;
   logic sclClean, sdaClean;
   logic sclPrev_q, sdaPrev_q;

   // Lines reset to the idle-high bus level so no edge is seen out of reset.
   always_ff @(posedge clk_200K or posedge reset) begin
      if (reset) begin
         sclSync_q <= '1;
         sdaSync_q <= '1;
      end else begin
         sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_i};
         sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_i};
      end
   end

   assign sclSynced = sclSync_q[SYNC_STAGES-1];
   assign sdaSynced = sdaSync_q[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
   logic [1:0] sclHist_q, sdaHist_q;
   logic       sclFilt_q, sdaFilt_q;

   always_ff @(posedge clk_200K or posedge reset) begin
      if (reset) begin
         sclHist_q <= '1;
         sdaHist_q <= '1;
         sclFilt_q <= 1'b1;
         sdaFilt_q <= 1'b1;
      end else begin
         sclHist_q <= {sclHist_q[0], sclSynced};
         sdaHist_q <= {sdaHist_q[0], sdaSynced};
         sclFilt_q <= majority3(sclSynced, sclHist_q[0], sclHist_q[1]);
         sdaFilt_q <= majority3(sdaSynced, sdaHist_q[0], sdaHist_q[1]);
      end
   end

   assign sclClean = sclFilt_q;
   assign sdaClean = sdaFilt_q;
`else
   assign sclClean = sclSynced;
   assign sdaClean = sdaSynced;
`endif

   always_ff @(posedge clk_200K or posedge reset) begin
      if (reset) begin
         sclPrev_q <= 1'b1;
         sdaPrev_q <= 1'b1;
      end else begin
         sclPrev_q <= sclClean;
         sdaPrev_q <= sdaClean;
      end
   end

   assign sdaLevel_o = sdaClean;
   assign sclRise_o  = sclClean & ~sclPrev_q;
   assign sclFall_o  = ~sclClean & sclPrev_q;
   assign start_o    = sclClean & sdaPrev_q & ~sdaClean;
   assign stop_o     = sclClean & ~sdaPrev_q & sdaClean;

endmodule

// File: rtl/i2c_temp_responder.sv
// I2C responder emulating the board temperature sensor: reads return a coherent
// 16-bit snapshot, writes set the pointer byte. Glitch filter: I2C_GLITCH_FILTER_EN.
module i2c_temp_responder import i2c_pkg::*; #(
   parameter logic [6:0] DEV_ADDR    = I2C_DEFAULT_DEV_ADDR,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                  clk_200K,
   input  logic                  reset,
   i2c_temp_responder_if.slave   bus
);

   logic sdaLevel, sclRise, sclFall, startDet, stopDet;

   i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) lineCond (
      .clk_200K   (clk_200K),
      .reset      (reset),
      .scl_i      (bus.scl_in),
      .sda_i      (bus.sda_in),
      .sdaLevel_o (sdaLevel),
      .sclRise_o  (sclRise),
      .sclFall_o  (sclFall),
      .start_o    (startDet),
      .stop_o     (stopDet)
   );

   i2cState_t   state_q, state_d;
   logic [3:0]  bitCnt_q, bitCnt_d;
   logic [7:0]  shiftReg_q, shiftReg_d;
   logic [15:0] snapshot_q, snapshot_d;
   logic        byteSel_q, byteSel_d;
   logic        sdaPullLow_q, sdaPullLow_d;
   logic [7:0]  ptrReg_q, ptrReg_d;
   logic        busy_q, busy_d;
   logic        rdDone_q, rdDone_d;
   logic        wrDone_q, wrDone_d;
   logic [7:0]  txByte;

   assign txByte = byteSel_q ? snapshot_q[7:0] : snapshot_q[15:8];

   always_ff @(posedge clk_200K or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         bitCnt_q     <= '0;
         shiftReg_q   <= '0;
         snapshot_q   <= '0;
         byteSel_q    <= 1'b0;
         sdaPullLow_q <= 1'b0;
         ptrReg_q     <= '0;
         busy_q       <= 1'b0;
         rdDone_q     <= 1'b0;
         wrDone_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         bitCnt_q     <= bitCnt_d;
         shiftReg_q   <= shiftReg_d;
         snapshot_q   <= snapshot_d;
         byteSel_q    <= byteSel_d;
         sdaPullLow_q <= sdaPullLow_d;
         ptrReg_q     <= ptrReg_d;
         busy_q       <= busy_d;
         rdDone_q     <= rdDone_d;
         wrDone_q     <= wrDone_d;
      end
   end

   // Bits are sampled on SCL rise; SDA is only ever changed on SCL fall, so
   // byte ends are decided on the fall that follows the eighth rise.
   always_comb begin
      state_d      = state_q;
      bitCnt_d     = bitCnt_q;
      shiftReg_d   = shiftReg_q;
      snapshot_d   = snapshot_q;
      byteSel_d    = byteSel_q;
      sdaPullLow_d = sdaPullLow_q;
      ptrReg_d     = ptrReg_q;
      busy_d       = busy_q;
      rdDone_d     = 1'b0;
      wrDone_d     = 1'b0;

      if (startDet) begin
         state_d      = ADDR;
         bitCnt_d     = '0;
         sdaPullLow_d = 1'b0;
         busy_d       = 1'b0;
      end else if (stopDet) begin
         state_d      = IDLE;
         sdaPullLow_d = 1'b0;
         busy_d       = 1'b0;
      end else begin
         case (state_q)
            IDLE: ;
            ADDR, RX_BYTE: begin
               if (sclRise) begin
                  shiftReg_d = {shiftReg_q[6:0], sdaLevel};
                  bitCnt_d   = bitCnt_q + 4'd1;
               end else if (sclFall && bitCnt_q == 4'd8) begin
                  if (state_q == RX_BYTE) begin
                     state_d      = RX_ACK;
                     sdaPullLow_d = 1'b1;
                     ptrReg_d     = shiftReg_q;
                     wrDone_d     = 1'b1;
                  end else if (shiftReg_q[7:1] == DEV_ADDR) begin
                     state_d      = ADDR_ACK;
                     sdaPullLow_d = 1'b1;
                     busy_d       = 1'b1;
                     if (shiftReg_q[RW_BIT]) begin
                        snapshot_d = bus.temp_data;
                        byteSel_d  = 1'b0;
                     end
                  end else begin
                     state_d = WAIT_STOP;
                  end
               end
            end
            ADDR_ACK: begin
               if (sclFall) begin
                  bitCnt_d = '0;
                  if (shiftReg_q[RW_BIT]) begin
                     state_d      = TX_BYTE;
                     sdaPullLow_d = ~txByte[7];
                  end else begin
                     state_d      = RX_BYTE;
                     sdaPullLow_d = 1'b0;
                  end
               end
            end
            TX_BYTE: begin
               if (sclRise) begin
                  bitCnt_d = bitCnt_q + 4'd1;
               end else if (sclFall) begin
                  if (bitCnt_q == 4'd8) begin
                     state_d      = TX_ACK;
                     sdaPullLow_d = 1'b0;
                  end else begin
                     sdaPullLow_d = ~txByte[3'd7 - bitCnt_q[2:0]];
                  end
               end
            end
            TX_ACK: begin
               if (sclRise) begin
                  if (!sdaLevel) begin
                     state_d   = TX_BYTE;
                     bitCnt_d  = '0;
                     byteSel_d = ~byteSel_q;
                  end else begin
                     state_d  = WAIT_STOP;
                     rdDone_d = 1'b1;
                  end
               end
            end
            RX_ACK: begin
               if (sclFall) begin
                  state_d      = RX_BYTE;
                  bitCnt_d     = '0;
                  sdaPullLow_d = 1'b0;
               end
            end
            WAIT_STOP: sdaPullLow_d = 1'b0;
            default:   state_d = IDLE;
         endcase
      end
   end

   assign bus.sda_pull_low = sdaPullLow_q;
   assign bus.ptr_reg      = ptrReg_q;
   assign bus.busy         = busy_q;
   assign bus.rd_done      = rdDone_q;
   assign bus.wr_done      = wrDone_q;

endmodule

// File: tb/tb_i2c_temp_responder.sv
// Self-checking bench for i2c_temp_responder: bit-banged I2C master, transaction
// model of the sensor, and a per-SCL-bit check of the responder's SDA drive.
`timescale 1ns/1ps
module tb_i2c_temp_responder;
   import i2c_pkg::*;

   localparam logic [7:0] RD_ADDR = 8'h97;
   localparam logic [7:0] WR_ADDR = 8'h96;
`ifdef I2C_GLITCH_FILTER_EN
   localparam logic FILTER_EN = 1'b1;
`else
   localparam logic FILTER_EN = 1'b0;
`endif

   logic        clk_200K = 1'b0;
   logic        reset    = 1'b1;
   logic        sclDrv   = 1'b1;
   logic        sdaDrv   = 1'b1;
   logic        expPull  = 1'b0;
   logic        checkEn  = 1'b0;
   logic [15:0] tempDrv  = 16'h0000;

   int total = 0;
   int bad = 0;
   int rdCount = 0;
   int wrCount = 0;
   int expRd = 0;
   int expWr = 0;
   logic [7:0] modelPtr = 8'h00;
   logic [7:0] gotBytes [0:7];
   logic [7:0] wrData [0:3];

   always #5 clk_200K = ~clk_200K;

   i2c_temp_responder_if bus();
   assign bus.scl_in    = sclDrv;
   assign bus.sda_in    = sdaDrv & ~bus.sda_pull_low;
   assign bus.temp_data = tempDrv;

   i2c_temp_responder #(.DEV_ADDR(7'h4B), .SYNC_STAGES(2)) dut (
      .clk_200K (clk_200K),
      .reset    (reset),
      .bus      (bus)
   );

   always @(negedge clk_200K) begin
      if (bus.rd_done) rdCount++;
      if (bus.wr_done) wrCount++;
   end

   initial begin
      #3ms;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic compareLoop();
      forever begin
         @(posedge sclDrv);
         if (checkEn) checkOutput("sdaPullAtSclHigh", 32'(bus.sda_pull_low), 32'(expPull));
      end
   endtask

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk_200K);
   endtask

   task automatic clockBit(input logic mBit, input logic pullExp, input logic glitch, output logic seen);
      sclDrv = 1'b0;
      waitClk(5);
      sdaDrv = mBit;
      waitClk(5);
      expPull = pullExp;
      sclDrv = 1'b1;
      waitClk(3);
      if (glitch) begin
         sdaDrv = 1'b0;
         waitClk(1);
         sdaDrv = 1'b1;
         waitClk(1);
      end else begin
         waitClk(2);
      end
      seen = bus.sda_in;
      waitClk(5);
   endtask

   task automatic startCond(input logic repeated);
      expPull = 1'b0;
      if (repeated) begin
         sclDrv = 1'b0;
         waitClk(5);
         sdaDrv = 1'b1;
         waitClk(5);
         sclDrv = 1'b1;
         waitClk(5);
      end
      sdaDrv = 1'b0;
      waitClk(5);
   endtask

   task automatic stopCond();
      expPull = 1'b0;
      sclDrv = 1'b0;
      waitClk(5);
      sdaDrv = 1'b0;
      waitClk(5);
      sclDrv = 1'b1;
      waitClk(5);
      sdaDrv = 1'b1;
      waitClk(10);
   endtask

   task automatic applyStimulus(input logic [7:0] b, input logic ackExp, input int glitchIdx, output logic acked);
      logic seen;
      for (int i = 0; i < 8; i++) clockBit(b[7-i], 1'b0, i == glitchIdx, seen);
      clockBit(1'b1, ackExp, 1'b0, seen);
      acked = ~seen;
   endtask

   task automatic recvByte(input logic [7:0] expB, input logic mAck, input int changeAt,
                           input logic [15:0] newTemp, output logic [7:0] got);
      logic seen;
      for (int i = 0; i < 8; i++) begin
         clockBit(1'b1, ~expB[7-i], 1'b0, seen);
         got[7-i] = seen;
         if (i == changeAt) tempDrv = newTemp;
      end
      clockBit(~mAck, 1'b0, 1'b0, seen);
   endtask

   function automatic logic [7:0] modelRdByte(input logic [15:0] snap, input int k);
      return (k % 2 == 0) ? snap[15:8] : snap[7:0];
   endfunction

   task automatic readTxn(input logic restart, input int nBytes, input int changeAt, input logic [15:0] newTemp);
      logic [15:0] snap;
      logic [7:0]  expB, got;
      logic        acked;
      snap = tempDrv;
      startCond(restart);
      applyStimulus(RD_ADDR, 1'b1, -1, acked);
      checkOutput("rdAddrAck", 32'(acked), 32'd1);
      checkOutput("busyAfterRdAddr", 32'(bus.busy), 32'd1);
      for (int k = 0; k < nBytes; k++) begin
         expB = modelRdByte(snap, k);
         recvByte(expB, k < nBytes - 1, (k == 0) ? changeAt : -1, newTemp, got);
         gotBytes[k] = got;
         checkOutput("rdByte", 32'(got), 32'(expB));
      end
      expRd++;
      stopCond();
      checkOutput("busyAfterRdStop", 32'(bus.busy), 32'd0);
      checkOutput("rdDoneCount", 32'(rdCount), 32'(expRd));
   endtask

   task automatic writeTxn(input int nBytes, input logic doStop);
      logic acked;
      startCond(1'b0);
      applyStimulus(WR_ADDR, 1'b1, -1, acked);
      checkOutput("wrAddrAck", 32'(acked), 32'd1);
      for (int k = 0; k < nBytes; k++) begin
         applyStimulus(wrData[k], 1'b1, -1, acked);
         checkOutput("wrDataAck", 32'(acked), 32'd1);
         modelPtr = wrData[k];
         expWr++;
         checkOutput("ptrReg", 32'(bus.ptr_reg), 32'(modelPtr));
      end
      checkOutput("wrDoneCount", 32'(wrCount), 32'(expWr));
      if (doStop) begin
         stopCond();
         checkOutput("busyAfterWrStop", 32'(bus.busy), 32'd0);
      end
   endtask

   task automatic badAddrTxn(input logic [7:0] a, input logic [7:0] extra);
      logic acked;
      startCond(1'b0);
      applyStimulus(a, 1'b0, -1, acked);
      checkOutput("badAddrNack", 32'(acked), 32'd0);
      checkOutput("busyBadAddr", 32'(bus.busy), 32'd0);
      applyStimulus(extra, 1'b0, -1, acked);
      checkOutput("waitStopNack", 32'(acked), 32'd0);
      stopCond();
      checkOutput("ptrAfterBadAddr", 32'(bus.ptr_reg), 32'(modelPtr));
      checkOutput("busyAfterBadStop", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      logic       acked;
      logic [7:0] a;
      int         sel, n;

      waitClk(4);
      checkOutput("resetPull", 32'(bus.sda_pull_low), 32'd0);
      checkOutput("resetBusy", 32'(bus.busy), 32'd0);
      checkOutput("resetPtr", 32'(bus.ptr_reg), 32'd0);
      checkOutput("resetRdDone", 32'(bus.rd_done), 32'd0);
      checkOutput("resetWrDone", 32'(bus.wr_done), 32'd0);
      reset = 1'b0;
      waitClk(5);
      checkEn = 1'b1;
      fork
         compareLoop();
      join_none

      // Plain read: MSB then LSB, NACK on the second byte.
      tempDrv = 16'h0C80;
      readTxn(1'b0, 2, -1, 16'h0000);
      checkOutput("litMsb", 32'(gotBytes[0]), 32'h0C);
      checkOutput("litLsb", 32'(gotBytes[1]), 32'h80);
      checkOutput("litRdCount", 32'(rdCount), 32'd1);

      badAddrTxn(8'h91, 8'hFF);

      // Pointer write, then repeated START into a read.
      wrData[0] = 8'h03;
      writeTxn(1, 1'b0);
      checkOutput("litPtr", 32'(bus.ptr_reg), 32'h03);
      checkOutput("litWrCount", 32'(wrCount), 32'd1);
      tempDrv = 16'hBEEF;
      readTxn(1'b1, 2, -1, 16'h0000);
      checkOutput("litRestartMsb", 32'(gotBytes[0]), 32'hBE);

      // Temperature changes mid-MSB; three bytes wrap without re-snapshot.
      tempDrv = 16'h0C80;
      readTxn(1'b0, 3, 3, 16'h1234);
      checkOutput("litCohMsb", 32'(gotBytes[0]), 32'h0C);
      checkOutput("litCohLsb", 32'(gotBytes[1]), 32'h80);
      checkOutput("litCohWrap", 32'(gotBytes[2]), 32'h0C);

      // Single-sample SDA low pulse during the address MSB.
      startCond(1'b0);
      applyStimulus(WR_ADDR, FILTER_EN, 0, acked);
      checkOutput("glitchAck", 32'(acked), 32'(FILTER_EN));
      checkOutput("glitchBusy", 32'(bus.busy), 32'(FILTER_EN));
      stopCond();
      checkOutput("glitchPtr", 32'(bus.ptr_reg), 32'(modelPtr));

      // Asynchronous reset while the responder drives a 0 in the MSB byte.
      tempDrv = 16'h0C80;
      startCond(1'b0);
      applyStimulus(RD_ADDR, 1'b1, -1, acked);
      checkOutput("preResetAck", 32'(acked), 32'd1);
      sclDrv = 1'b0;
      waitClk(8);
      checkOutput("pullBeforeReset", 32'(bus.sda_pull_low), 32'd1);
      #2 reset = 1'b1;
      #1;
      checkOutput("asyncResetPull", 32'(bus.sda_pull_low), 32'd0);
      checkOutput("asyncResetBusy", 32'(bus.busy), 32'd0);
      checkOutput("asyncResetPtr", 32'(bus.ptr_reg), 32'd0);
      modelPtr = 8'h00;
      expPull = 1'b0;
      waitClk(2);
      sdaDrv = 1'b1;
      sclDrv = 1'b1;
      waitClk(4);
      reset = 1'b0;
      waitClk(10);
      tempDrv = 16'h5A3C;
      readTxn(1'b0, 2, -1, 16'h0000);

      // Randomized mix of reads, writes and foreign addresses.
      for (int t = 0; t < 16; t++) begin
         sel = $urandom_range(0, 2);
         if (sel == 0) begin
            tempDrv = 16'($urandom);
            n = $urandom_range(1, 4);
            readTxn(1'b0, n, $urandom_range(0, 7), 16'($urandom));
         end else if (sel == 1) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) wrData[k] = 8'($urandom);
            writeTxn(n, 1'b1);
         end else begin
            a = 8'($urandom);
            if (a[7:1] == 7'h4B) a[2] = ~a[2];
            badAddrTxn(a, 8'($urandom));
         end
      end

      checkOutput("finalPtr", 32'(bus.ptr_reg), 32'(modelPtr));
      checkOutput("finalRdCount", 32'(rdCount), 32'(expRd));
      checkOutput("finalWrCount", 32'(wrCount), 32'(expWr));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
